// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encoding and multiplier length.
package ex_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam int MUL_CYCLES = 32;
endpackage

// File: rtl/ex_stage_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_WIDTH bits of the product.
module seq_mul
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [CNT_W-1:0]      cnt_p0;
    logic [DATA_WIDTH-1:0] acc_p0;
    logic [DATA_WIDTH-1:0] mcand_p0;
    logic [DATA_WIDTH-1:0] mplier_p0;
    logic [DATA_WIDTH-1:0] acc_next;

    // The final step's partial sum is exposed directly so the product lands on the done edge.
    assign acc_next = mplier_p0[0] ? acc_p0 + mcand_p0 : acc_p0;
    assign done     = busy && (cnt_p0 == CNT_W'(MUL_CYCLES - 1));
    assign product  = acc_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy      <= 1'b0;
            cnt_p0    <= '0;
            acc_p0    <= '0;
            mcand_p0  <= '0;
            mplier_p0 <= '0;
        end else if (busy) begin
            acc_p0    <= acc_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            cnt_p0    <= cnt_p0 + 1'b1;
            if (done) busy <= 1'b0;
        end else if (start) begin
            acc_p0    <= '0;
            mcand_p0  <= a;
            mplier_p0 <= b;
            cnt_p0    <= '0;
            busy      <= 1'b1;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a stalling iterative MUL, registered result for writeback.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [3:0]            i_op,
    input  logic                  i_use_imm,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_rf1,
    input  logic [DATA_WIDTH-1:0] i_rf2,
    input  logic [4:0]            i_rfd_idx,
    output logic                  o_d_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rfd_idx,
    output logic                  o_busy
);
    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]        op_b;
    logic signed [DATA_WIDTH-1:0] op_a_s;
    logic signed [DATA_WIDTH-1:0] op_b_s;
    logic [4:0]                   shamt;
    logic [DATA_WIDTH-1:0]        alu_res;
    logic                         accept;
    logic                         mul_start;
    logic                         mul_busy;
    logic                         mul_done;
    logic [DATA_WIDTH-1:0]        mul_product;
    logic [4:0]                   mul_idx_p0;
    logic                         vld_p1;
    logic [DATA_WIDTH-1:0]        result_p1;
    logic [4:0]                   rfd_idx_p1;

    assign op_b      = i_use_imm ? i_imm : i_rf2;
    assign op_a_s    = i_rf1;
    assign op_b_s    = op_b;
    assign shamt     = op_b[4:0];
    assign accept    = (state_q == S_IDLE) && i_valid;
    assign mul_start = accept && (i_op == OP_MUL);

    always_comb begin
        alu_res = '0;
        case (i_op)
            OP_ADD:  alu_res = i_rf1 + op_b;
            OP_SUB:  alu_res = i_rf1 - op_b;
            OP_AND:  alu_res = i_rf1 & op_b;
            OP_OR:   alu_res = i_rf1 | op_b;
            OP_XOR:  alu_res = i_rf1 ^ op_b;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
            OP_SLL:  alu_res = i_rf1 << shamt;
            OP_SRL:  alu_res = i_rf1 >> shamt;
            OP_SRA:  alu_res = op_a_s >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        o_d_en  = 1'b1;
        case (state_q)
            S_IDLE: if (mul_start) state_d = S_MUL;
            S_MUL: begin
                o_d_en = 1'b0;
                if (mul_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    seq_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (mul_start),
        .a       (i_rf1),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Writeback register stage: ALU results on accept, MUL result on the multiplier's last step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1     <= 1'b0;
            result_p1  <= '0;
            rfd_idx_p1 <= '0;
            mul_idx_p0 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (mul_start) begin
                mul_idx_p0 <= i_rfd_idx;
            end else if (accept) begin
                vld_p1     <= 1'b1;
                result_p1  <= alu_res;
                rfd_idx_p1 <= i_rfd_idx;
            end
            if (mul_done) begin
                vld_p1     <= 1'b1;
                result_p1  <= mul_product;
                rfd_idx_p1 <= mul_idx_p0;
            end
        end
    end

    assign o_valid   = vld_p1;
    assign o_result  = result_p1;
    assign o_rfd_idx = rfd_idx_p1;
    assign o_busy    = mul_busy;
endmodule

// File: tb/tb_ex_stage.sv
// Randomised self-checking bench for ex_stage against a plain-arithmetic reference model.
module tb_ex_stage;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_op = 4'd0;
    logic        i_use_imm = 1'b0;
    logic [31:0] i_imm = '0;
    logic [31:0] i_rf1 = '0;
    logic [31:0] i_rf2 = '0;
    logic [4:0]  i_rfd_idx = '0;
    logic        o_d_en;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rfd_idx;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    ex_stage #(.DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op),
        .i_use_imm(i_use_imm), .i_imm(i_imm), .i_rf1(i_rf1), .i_rf2(i_rf2),
        .i_rfd_idx(i_rfd_idx), .o_d_en(o_d_en), .o_valid(o_valid),
        .o_result(o_result), .o_rfd_idx(o_rfd_idx), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return a << sh;
            7: return a >> sh;
            8: return sa >>> sh;
            9: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input int op, input logic ui, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] idx);
        i_valid = v; i_op = 4'(op); i_use_imm = ui; i_rf1 = a; i_rf2 = r2; i_imm = imm; i_rfd_idx = idx;
    endtask

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({o_d_en, o_valid, o_busy, o_result, o_rfd_idx} !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset: d_en=%b valid=%b busy=%b result=%h idx=%0d, want 1 0 0 0 0",
                     o_d_en, o_valid, o_busy, o_result, o_rfd_idx);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_directed();
        logic [31:0] want [4];
        int          ops  [4];
        logic [31:0] as   [4];
        logic [31:0] bs   [4];
        ops = '{0, 1, 8, 5};
        as  = '{32'd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF};
        bs  = '{32'd7, 32'd1, 32'd4, 32'd1};
        want = '{32'd12, 32'hFFFF_FFFF, 32'hF800_0000, 32'd1};
        for (int i = 0; i < 4; i++) begin
            // SUB takes its B operand from the immediate; rf2 carries junk to prove the mux.
            if (ops[i] == 1) drive(1'b1, ops[i], 1'b1, as[i], 32'hDEAD_BEEF, bs[i], 5'(3 + i));
            else             drive(1'b1, ops[i], 1'b0, as[i], bs[i], 32'h1234_5678, 5'(3 + i));
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_result !== want[i] || o_rfd_idx !== 5'(3 + i) || o_d_en !== 1'b1) begin
                errors++;
                $display("FAIL alu_directed[%0d]: valid=%b result=%h idx=%0d d_en=%b, want 1 %h %0d 1",
                         i, o_valid, o_result, o_rfd_idx, o_d_en, want[i], 3 + i);
            end
        end
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_alu_random();
        logic [31:0] last_res;
        logic [4:0]  last_idx;
        logic [31:0] exp_res;
        logic [4:0]  exp_idx;
        logic        exp_vld;
        logic [31:0] a, r2, imm, b;
        logic        ui, v;
        int          op;
        last_res = o_result;
        last_idx = o_rfd_idx;
        for (int n = 0; n < 60; n++) begin
            v   = ($urandom_range(0, 4) != 0);
            op  = $urandom_range(0, 15);
            if (op == 9) op = 12;
            ui  = 1'($urandom_range(0, 1));
            a   = $urandom;
            r2  = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) == 0) r2 = 32'($urandom_range(0, 40));
            b   = ui ? imm : r2;
            drive(v, op, ui, a, r2, imm, 5'($urandom_range(0, 31)));
            exp_vld = v;
            exp_res = v ? ref_alu(op, a, b) : last_res;
            exp_idx = v ? i_rfd_idx : last_idx;
            tick();
            checks++;
            if (o_valid !== exp_vld || o_result !== exp_res || o_rfd_idx !== exp_idx) begin
                errors++;
                $display("FAIL alu_random[%0d] op=%0d: valid=%b result=%h idx=%0d, want %b %h %0d",
                         n, op, o_valid, o_result, o_rfd_idx, exp_vld, exp_res, exp_idx);
            end
            last_res = exp_res;
            last_idx = exp_idx;
        end
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_mul();
        logic [31:0] as [4];
        logic [31:0] bs [4];
        int          stall;
        logic        early_vld;
        as = '{32'h0001_0003, 32'hFFFF_FFFF, $urandom, $urandom};
        bs = '{32'd5, 32'hFFFF_FFFF, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9, 1'b0, as[i], bs[i], 32'd0, 5'(7 + i));
            tick();
            // Inputs are garbage while stalled; the stage must ignore them.
            drive(1'b1, 1, 1'b0, $urandom, $urandom, $urandom, 5'd31);
            stall = 0;
            early_vld = 1'b0;
            while (o_d_en === 1'b0 && stall < 100) begin
                if (o_valid !== 1'b0 || o_busy !== 1'b1) early_vld = 1'b1;
                stall++;
                tick();
            end
            drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
            checks++;
            if (stall != 32 || early_vld) begin
                errors++;
                $display("FAIL mul_stall[%0d]: stall=%0d bad_during=%b, want 32 0", i, stall, early_vld);
            end
            checks++;
            if (o_valid !== 1'b1 || o_result !== ref_alu(9, as[i], bs[i]) || o_rfd_idx !== 5'(7 + i) || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL mul_result[%0d]: valid=%b result=%h idx=%0d busy=%b, want 1 %h %0d 0",
                         i, o_valid, o_result, o_rfd_idx, o_busy, ref_alu(9, as[i], bs[i]), 7 + i);
            end
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_pulse[%0d]: valid=%b, want 0", i, o_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int stall;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        drive(1'b1, 9, 1'b0, a, b, 32'd0, 5'd9);
        tick();
        drive(1'b1, 0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd4);
        stall = 0;
        while (o_d_en === 1'b0 && stall < 100) begin
            stall++;
            tick();
        end
        checks++;
        if (stall != 32 || o_valid !== 1'b1 || o_result !== a * b || o_rfd_idx !== 5'd9) begin
            errors++;
            $display("FAIL b2b_mul: stall=%0d valid=%b result=%h idx=%0d, want 32 1 %h 9",
                     stall, o_valid, o_result, o_rfd_idx, a * b);
        end
        tick();
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd2 || o_rfd_idx !== 5'd4 || o_d_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_add: valid=%b result=%h idx=%0d d_en=%b, want 1 2 4 1",
                     o_valid, o_result, o_rfd_idx, o_d_en);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 9, 1'b0, 32'h0000_1234, 32'h0000_5678, 32'd0, 5'd6);
        tick();
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
        repeat (10) tick();
        i_rst_n = 1'b0;
        #2;
        checks++;
        if (o_d_en !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_mul: d_en=%b busy=%b valid=%b result=%h, want 1 0 0 0",
                     o_d_en, o_busy, o_valid, o_result);
        end
        tick();
        i_rst_n = 1'b1;
        repeat (40) begin
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_d_en !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_pulse: valid=%b d_en=%b, want 0 1", o_valid, o_d_en);
            end
        end
        drive(1'b1, 0, 1'b0, 32'd20, 32'd22, 32'd0, 5'd2);
        tick();
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd42 || o_rfd_idx !== 5'd2) begin
            errors++;
            $display("FAIL post_reset_add: valid=%b result=%h idx=%0d, want 1 42 2",
                     o_valid, o_result, o_rfd_idx);
        end
        tick();
    endtask

    task automatic test_undef_hold();
        logic [31:0] held;
        drive(1'b1, 12, 1'b0, 32'hFFFF_0000, 32'h1111, 32'd0, 5'd0);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd0 || o_rfd_idx !== 5'd0) begin
            errors++;
            $display("FAIL undef_op: valid=%b result=%h idx=%0d, want 1 0 0", o_valid, o_result, o_rfd_idx);
        end
        drive(1'b1, 4, 1'b0, 32'hA5A5_0F0F, 32'h0F0F_FFFF, 32'd0, 5'd13);
        tick();
        held = 32'hA5A5_0F0F ^ 32'h0F0F_FFFF;
        drive(1'b0, 0, 1'b1, $urandom, $urandom, $urandom, 5'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_result !== held || o_rfd_idx !== 5'd13) begin
                errors++;
                $display("FAIL idle_hold[%0d]: valid=%b result=%h idx=%0d, want 0 %h 13",
                         i, o_valid, o_result, o_rfd_idx, held);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_undef_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage sitting directly downstream of the decode-stage pipeline register. Each cycle it consumes one decoded instruction: immediate, two register-file operands, destination index, opcode and valid. It produces a registered result with its destination index for writeback. Single-cycle ALU ops complete in one cycle. MUL runs on an iterative shift-add engine, and the stage drives the decode register's write-enable low to freeze it until the product is ready.

## Interface
- DATA_WIDTH, 32, operand/result width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  decode register holds a valid instruction
- i_op  in  4  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, MUL=9; 10–15 undefined
- i_use_imm  in  1  operand B = i_imm when 1, else i_rf2
- i_imm  in  DATA_WIDTH  immediate from decode register
- i_rf1  in  DATA_WIDTH  operand A
- i_rf2  in  DATA_WIDTH  register operand B
- i_rfd_idx  in  5  destination register index
- o_d_en  out  1  write-enable to decode register; 0 = hold
- o_valid  out  1  result valid, one-cycle pulse per instruction
- o_result  out  DATA_WIDTH  registered result
- o_rfd_idx  out  5  registered destination index
- o_busy  out  1  multiplier active

## Operation
- FSM states:
  - IDLE: o_d_en=1.
  - MUL: o_d_en=0, o_busy=1.
- IDLE, i_valid=1, single-cycle op:
  - result = f(A, B) is registered at the next edge.
  - o_rfd_idx = i_rfd_idx; o_valid=1 for one cycle.
  - State stays IDLE.
- IDLE, i_valid=1, op=MUL:
  - Latch A, B and i_rfd_idx.
  - Clear the accumulator; counter=0.
  - Go to MUL. o_valid=0 next cycle.
- MUL:
  - Each cycle: if multiplier bit0=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - At the edge ending counter=31: o_result = acc (low 32 bits, sign-agnostic), o_rfd_idx = latched idx, o_valid=1, go to IDLE.
  - i_valid and all inputs are ignored in MUL.
- i_valid=0 in IDLE: o_valid=0. o_result and o_rfd_idx hold their previous values.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - SLT is a signed compare: result 1 or 0.
  - Shift amount = B[4:0].
  - SRA replicates A[31].
- Undefined opcode: o_result=0, o_valid=1 (instruction retired, no trap).
- rfd_idx=0 is passed through unchanged; x0 suppression belongs to writeback.

## Timing
- Reset values:
  - State IDLE.
  - o_d_en=1, o_valid=0, o_busy=0.
  - o_result=0, o_rfd_idx=0.
  - Counter and accumulator 0.
- Single-cycle latency: accept at edge T, o_valid high during cycle T..T+1.
- MUL timing:
  - Accept at edge T0.
  - o_d_en=0 and o_busy=1 for exactly 32 cycles (T0..T32).
  - o_valid=1 in cycle T32..T33. o_d_en=1 in the same cycle.
- The decode register captures the next instruction at T0 and holds it during MUL. That instruction is accepted at the first IDLE edge (T33) with no bubble beyond the stall.
- o_d_en is a combinational decode of state only: no input-to-output path.
- Back-to-back MULs: the second is accepted at T33, so there is 1 IDLE cycle between stalls.
- Reset mid-MUL: immediate return to IDLE, o_d_en=1, no o_valid pulse, partial product discarded.

## Structure
- Package ex_pkg:
  - opcode localparams OP_ADD..OP_MUL
  - FSM state encoding (S_IDLE, S_MUL)
  - MUL_CYCLES = 32
- Sub-module seq_mul:
  - Iterative shift-add multiplier with start/busy/done handshake.
  - Owns the counter, accumulator and shift registers.
- ex_stage holds:
  - the FSM and the operand-B mux
  - the combinational ALU
  - the output registers and o_d_en
- Target ~200–300 lines total.

## Test plan
- ADD A=5, B(rf2)=7, rfd=3, i_valid=1 → next cycle o_valid=1, o_result=12, o_rfd_idx=3; o_d_en stays 1.
- SUB with i_use_imm=1, A=0, imm=1 → o_result=0xFFFF_FFFF. SRA A=0x8000_0000, B=4 → 0xF800_0000. SLT A=0xFFFF_FFFF, B=1 → 1.
- MUL A=0x0001_0003, B=5, rfd=7:
  - o_d_en low exactly 32 cycles.
  - Then o_result=0x0005_000F, o_rfd_idx=7, o_valid one cycle.
  - MUL 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001.
- MUL followed by ADD 1+1 (rfd=4) held in decode register:
  - ADD ignored during the stall.
  - ADD accepted at the first IDLE edge → o_result=2 exactly one cycle after the MUL result.
- Reset asserted 10 cycles into MUL → o_d_en=1, o_busy=0, o_valid=0, o_result=0. A subsequent ADD completes normally.
- Undefined opcode 12 → o_valid=1, o_result=0. i_valid=0 for 5 cycles → o_valid stays 0 and o_result holds its last value.
